// File: rtl/uart_arb_pkg.sv
// Shared state encoding and counter widths for the UART transmit arbiter.
package uart_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_XFER  = 1'b1;

  localparam int BEAT_W   = 8;
  localparam int IDLE_W   = 16;
  localparam int NREQ_MAX = 8;

  typedef logic [BEAT_W-1:0] beat_cnt_t;
  typedef logic [IDLE_W-1:0] idle_cnt_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr_s+1, wrapping modulo NREQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_s,
  input  logic [PW-1:0]   ptr_s,
  output logic [NREQ-1:0] win_s,
  output logic [PW-1:0]   win_idx_s,
  output logic            any_s
);

  logic          hit_s;
  logic [PW-1:0] cand_s;

  // Rotating priority search starting just past the previous winner.
  always_comb begin
    win_s     = '0;
    win_idx_s = '0;
    hit_s     = 1'b0;
    cand_s    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = PW'((int'(ptr_s) + i) % NREQ);
      if (!hit_s && req_s[cand_s]) begin
        hit_s          = 1'b1;
        win_s[cand_s]  = 1'b1;
        win_idx_s      = cand_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign any_s = |req_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte stream among NREQ
// message-oriented requesters, with burst limit and stall timeout release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8*NREQ-1:0] req_tdata,
  input  logic [NREQ-1:0]   req_tvalid,
  input  logic [NREQ-1:0]   req_tlast,
  output logic [NREQ-1:0]   req_tready,
  output logic [7:0]        tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int        PW       = $clog2(NREQ);
  localparam beat_cnt_t BEAT_ONE = BEAT_W'(1);
  localparam beat_cnt_t BEAT_MAX = BEAT_W'(MAXBURST);
  localparam idle_cnt_t IDLE_ONE = IDLE_W'(1);
  localparam idle_cnt_t IDLE_MAX = IDLE_W'(TIMEOUT);

  logic [0:0]      state_r, state_nx_s;
  logic [NREQ-1:0] grant_r, grant_nx_s;
  logic [PW-1:0]   ptr_r, ptr_nx_s;
  beat_cnt_t       beat_cnt_r, beat_nx_s, beat_inc_s;
  idle_cnt_t       idle_cnt_r, idle_nx_s, idle_inc_s;
  logic [7:0]      tx_data_r, tx_data_nx_s;
  logic            tx_valid_r, tx_valid_nx_s;
  logic            busy_r, busy_nx_s;
  logic            tevt_r, tevt_nx_s;

  logic [NREQ-1:0] pick_win_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_any_s;

  logic            slot_free_s;
  logic            own_valid_s;
  logic            own_last_s;
  logic [7:0]      own_data_s;
  logic            accept_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_s     (req_tvalid),
    .ptr_s     (ptr_r),
    .win_s     (pick_win_s),
    .win_idx_s (pick_idx_s),
    .any_s     (pick_any_s)
  );

  // The pointer always holds the current owner's index while in XFER.
  assign slot_free_s = ~tx_valid_r | tx_tready;
  assign own_valid_s = req_tvalid[ptr_r];
  assign own_last_s  = req_tlast[ptr_r];
  assign own_data_s  = req_tdata[{ptr_r, 3'b000} +: 8];
  assign accept_s    = (state_r == ST_XFER) & own_valid_s & slot_free_s;
  assign beat_inc_s  = beat_cnt_r + BEAT_ONE;
  assign idle_inc_s  = idle_cnt_r + IDLE_ONE;

  // Only the owner sees ready, and only while the output slot can take a byte.
  always_comb begin
    req_tready = '0;
    if (state_r == ST_XFER) begin
      req_tready = grant_r & {NREQ{slot_free_s}};
    end else begin
      req_tready = '0;
    end
  end

  // Grant FSM: arbitration, burst/tlast release and stall timeout.
  always_comb begin
    state_nx_s = state_r;
    grant_nx_s = grant_r;
    ptr_nx_s   = ptr_r;
    beat_nx_s  = beat_cnt_r;
    idle_nx_s  = idle_cnt_r;
    tevt_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_nx_s = '0;
        if (pick_any_s) begin
          state_nx_s = ST_XFER;
          grant_nx_s = pick_win_s;
          ptr_nx_s   = pick_idx_s;
          beat_nx_s  = '0;
          idle_nx_s  = '0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s) begin
          beat_nx_s = beat_inc_s;
          idle_nx_s = '0;
          if (own_last_s || (beat_inc_s == BEAT_MAX)) begin
            state_nx_s = ST_IDLE;
            grant_nx_s = '0;
          end else begin
            state_nx_s = ST_XFER;
          end
        end else if (own_valid_s) begin
          // Stalled by the transmitter, not by the requester.
          idle_nx_s = '0;
        end else begin
          idle_nx_s = idle_inc_s;
          if (idle_inc_s == IDLE_MAX) begin
            state_nx_s = ST_IDLE;
            grant_nx_s = '0;
            tevt_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_XFER;
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        grant_nx_s = '0;
      end
    endcase
  end

  // Output register: load on accept, drain when the transmitter takes it.
  always_comb begin
    tx_data_nx_s  = tx_data_r;
    tx_valid_nx_s = tx_valid_r;
    if (accept_s) begin
      tx_data_nx_s  = own_data_s;
      tx_valid_nx_s = 1'b1;
    end else if (tx_tready) begin
      tx_valid_nx_s = 1'b0;
    end else begin
      tx_valid_nx_s = tx_valid_r;
    end
    busy_nx_s = (state_nx_s == ST_XFER) | tx_valid_nx_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      ptr_r      <= PW'(NREQ - 1);
      beat_cnt_r <= '0;
      idle_cnt_r <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      tevt_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      grant_r    <= grant_nx_s;
      ptr_r      <= ptr_nx_s;
      beat_cnt_r <= beat_nx_s;
      idle_cnt_r <= idle_nx_s;
      tx_data_r  <= tx_data_nx_s;
      tx_valid_r <= tx_valid_nx_s;
      busy_r     <= busy_nx_s;
      tevt_r     <= tevt_nx_s;
    end
  end

  assign tx_tdata    = tx_data_r;
  assign tx_tvalid   = tx_valid_r;
  assign grant       = grant_r;
  assign busy        = busy_r;
  assign timeout_evt = tevt_r;

endmodule
